// File: rtl/vita49_pkg.sv
// Shared definitions for the VITA-49 IF-data packer/unpacker pair.
package vita49_pkg;

  // Fixed header: header word, stream ID, integer seconds, fractional hi, fractional lo.
  localparam int VRT_HDR_WORDS = 5;

  // Header word bit positions
  localparam int HDR_TYPE_MSB = 31;
  localparam int HDR_TYPE_LSB = 28;
  localparam int HDR_TSI_MSB  = 23;
  localparam int HDR_TSI_LSB  = 22;
  localparam int HDR_TSF_MSB  = 21;
  localparam int HDR_TSF_LSB  = 20;
  localparam int HDR_SEQ_MSB  = 19;
  localparam int HDR_SEQ_LSB  = 16;
  localparam int HDR_SIZE_MSB = 15;
  localparam int HDR_SIZE_LSB = 0;

  // Field codes
  localparam logic [3:0] VRT_TYPE_IFDATA_SID = 4'b0001;
  localparam logic [1:0] VRT_TSI_UTC         = 2'b01;
  localparam logic [1:0] VRT_TSF_REAL        = 2'b10;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_SID,
    ST_TSI,
    ST_TSF_HI,
    ST_TSF_LO,
    ST_PAY,
    ST_DROP
  } vita49_state_t;

  // Builds an IF-data header word with the codes this link always uses.
  function automatic logic [31:0] vrt_hdr(input logic [3:0] seq, input logic [15:0] size);
    return {VRT_TYPE_IFDATA_SID, 4'h0, VRT_TSI_UTC, VRT_TSF_REAL, seq, size};
  endfunction

endpackage

// File: rtl/vita49_axis_oreg.sv
// One-entry AXI-Stream output register; accepts a new word in the same cycle the old one drains.
module vita49_axis_oreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;
  logic         load;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;

  // Load on accept, otherwise hold the word stable until the consumer takes it
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = in_data;
      last_d  = in_last;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/vita49_unpack.sv
// VITA-49 IF-data unpacker: checks header/SID/size/sequence, latches the timestamp, forwards payload.
module vita49_unpack
  import vita49_pkg::*;
#(
  parameter int HDR_WORDS = VRT_HDR_WORDS,
  parameter int CNT_W     = 32
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic [31:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TVALID,
  input  logic             S_AXIS_TLAST,
  output logic             S_AXIS_TREADY,
  output logic [31:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY,
  input  logic             enable,
  input  logic             sid_check,
  input  logic [31:0]      streamID,
  output logic [31:0]      ts_sec,
  output logic [63:0]      ts_fsec,
  output logic             ts_valid,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] sid_err,
  output logic [CNT_W-1:0] size_err,
  output logic [CNT_W-1:0] seq_err
);

  vita49_state_t    state_q, state_d;
  logic [15:0]      size_q, size_d;
  logic [15:0]      wcnt_q, wcnt_d;
  logic [3:0]       seq_q, seq_d;
  logic             seq_vld_q, seq_vld_d;
  logic [31:0]      sec_sh_q, sec_sh_d;
  logic [31:0]      fhi_sh_q, fhi_sh_d;
  logic [31:0]      ts_sec_q, ts_sec_d;
  logic [63:0]      ts_fsec_q, ts_fsec_d;
  logic             ts_valid_q, ts_valid_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0] sid_err_q, sid_err_d;
  logic [CNT_W-1:0] size_err_q, size_err_d;
  logic [CNT_W-1:0] seq_err_q, seq_err_d;

  logic        s_ready, s_hs;
  logic        pay_valid, pay_ready, pay_last;
  logic        ev_size, ev_sid, ev_pkt, ev_ts;
  logic        hdr_ok;
  logic [3:0]  in_type, in_seq;
  logic [15:0] in_size, word_idx;

  assign in_type  = S_AXIS_TDATA[HDR_TYPE_MSB:HDR_TYPE_LSB];
  assign in_seq   = S_AXIS_TDATA[HDR_SEQ_MSB:HDR_SEQ_LSB];
  assign in_size  = S_AXIS_TDATA[HDR_SIZE_MSB:HDR_SIZE_LSB];
  // 1-based position of the word currently on the input, header word being 1
  assign word_idx = wcnt_q + 16'd1;
  assign hdr_ok   = (in_type == VRT_TYPE_IFDATA_SID) && (in_size > 16'(HDR_WORDS));
  assign s_hs     = S_AXIS_TVALID && s_ready;

  assign S_AXIS_TREADY = s_ready;
  assign ts_sec        = ts_sec_q;
  assign ts_fsec       = ts_fsec_q;
  assign ts_valid      = ts_valid_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign sid_err       = sid_err_q;
  assign size_err      = size_err_q;
  assign seq_err       = seq_err_q;

  vita49_axis_oreg #(.W(32)) u_oreg (
    .clk      (AXIS_ACLK),
    .rst_n    (AXIS_ARESETN),
    .in_data  (S_AXIS_TDATA),
    .in_last  (pay_last),
    .in_valid (pay_valid),
    .in_ready (pay_ready),
    .out_data (M_AXIS_TDATA),
    .out_last (M_AXIS_TLAST),
    .out_valid(M_AXIS_TVALID),
    .out_ready(M_AXIS_TREADY)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q    <= ST_HDR;
      size_q     <= '0;
      wcnt_q     <= '0;
      seq_q      <= '0;
      seq_vld_q  <= 1'b0;
      sec_sh_q   <= '0;
      fhi_sh_q   <= '0;
      ts_sec_q   <= '0;
      ts_fsec_q  <= '0;
      ts_valid_q <= 1'b0;
      pkt_cnt_q  <= '0;
      sid_err_q  <= '0;
      size_err_q <= '0;
      seq_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      wcnt_q     <= wcnt_d;
      seq_q      <= seq_d;
      seq_vld_q  <= seq_vld_d;
      sec_sh_q   <= sec_sh_d;
      fhi_sh_q   <= fhi_sh_d;
      ts_sec_q   <= ts_sec_d;
      ts_fsec_q  <= ts_fsec_d;
      ts_valid_q <= ts_valid_d;
      pkt_cnt_q  <= pkt_cnt_d;
      sid_err_q  <= sid_err_d;
      size_err_q <= size_err_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Next state and the per-beat error/complete events; TLAST in the header always wins
  always_comb begin
    state_d = state_q;
    ev_size = 1'b0;
    ev_sid  = 1'b0;
    ev_pkt  = 1'b0;
    ev_ts   = 1'b0;
    if (s_hs) begin
      case (state_q)
        ST_HDR: begin
          if (!hdr_ok || S_AXIS_TLAST) begin
            ev_size = 1'b1;
            state_d = S_AXIS_TLAST ? ST_HDR : ST_DROP;
          end else begin
            state_d = ST_SID;
          end
        end
        ST_SID: begin
          if (S_AXIS_TLAST) begin
            ev_size = 1'b1;
            state_d = ST_HDR;
          end else if (sid_check && (S_AXIS_TDATA != streamID)) begin
            ev_sid  = 1'b1;
            state_d = ST_DROP;
          end else begin
            state_d = ST_TSI;
          end
        end
        ST_TSI: begin
          ev_size = S_AXIS_TLAST;
          state_d = S_AXIS_TLAST ? ST_HDR : ST_TSF_HI;
        end
        ST_TSF_HI: begin
          ev_size = S_AXIS_TLAST;
          state_d = S_AXIS_TLAST ? ST_HDR : ST_TSF_LO;
        end
        ST_TSF_LO: begin
          ev_size = S_AXIS_TLAST;
          ev_ts   = !S_AXIS_TLAST;
          state_d = S_AXIS_TLAST ? ST_HDR : ST_PAY;
        end
        ST_PAY: begin
          if (word_idx == size_q) begin
            ev_pkt  = S_AXIS_TLAST;
            ev_size = !S_AXIS_TLAST;
            state_d = S_AXIS_TLAST ? ST_HDR : ST_DROP;
          end else if (S_AXIS_TLAST) begin
            ev_size = 1'b1;
            state_d = ST_HDR;
          end
        end
        ST_DROP: begin
          if (S_AXIS_TLAST) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
    end
  end

  // Input ready per state and the payload hand-off into the output register
  always_comb begin
    case (state_q)
      ST_HDR:  s_ready = enable;
      ST_PAY:  s_ready = pay_ready;
      default: s_ready = 1'b1;
    endcase
    pay_valid = (state_q == ST_PAY) && S_AXIS_TVALID;
    pay_last  = S_AXIS_TLAST || (word_idx == size_q);
  end

  // Word counting, sequence tracking, timestamp capture and status counters
  always_comb begin
    size_d     = size_q;
    wcnt_d     = wcnt_q;
    seq_d      = seq_q;
    seq_vld_d  = seq_vld_q;
    sec_sh_d   = sec_sh_q;
    fhi_sh_d   = fhi_sh_q;
    ts_sec_d   = ts_sec_q;
    ts_fsec_d  = ts_fsec_q;
    ts_valid_d = ev_ts;
    pkt_cnt_d  = pkt_cnt_q;
    sid_err_d  = sid_err_q;
    size_err_d = size_err_q;
    seq_err_d  = seq_err_q;
    if (s_hs && (state_q == ST_HDR)) begin
      size_d = in_size;
      wcnt_d = 16'd1;
      if (hdr_ok) begin
        if (seq_vld_q && (in_seq != (seq_q + 4'd1))) seq_err_d = seq_err_q + CNT_W'(1);
        seq_d     = in_seq;
        seq_vld_d = 1'b1;
      end
    end else if (s_hs) begin
      wcnt_d = word_idx;
    end
    if (s_hs && (state_q == ST_TSI))    sec_sh_d = S_AXIS_TDATA;
    if (s_hs && (state_q == ST_TSF_HI)) fhi_sh_d = S_AXIS_TDATA;
    if (ev_ts) begin
      ts_sec_d  = sec_sh_q;
      ts_fsec_d = {fhi_sh_q, S_AXIS_TDATA};
    end
    if (ev_pkt)  pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
    if (ev_sid)  sid_err_d  = sid_err_q + CNT_W'(1);
    if (ev_size) size_err_d = size_err_q + CNT_W'(1);
  end

endmodule

// File: tb/tb_vita49_unpack.sv
// Self-checking bench for vita49_unpack: table of packets plus stall, reset and enable sequences.
module tb_vita49_unpack;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESETN;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;
  logic        enable;
  logic        sid_check;
  logic [31:0] streamID;
  logic [31:0] ts_sec;
  logic [63:0] ts_fsec;
  logic        ts_valid;
  logic [31:0] pkt_cnt, sid_err, size_err, seq_err;

  int total = 0;
  int bad = 0;
  int ready_mode = 0;
  int stall_viol = 0;
  int ts_pulses = 0;
  logic [32:0] out_q[$];
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  typedef struct {
    logic [3:0]  typ;
    logic [3:0]  seq;
    logic [15:0] size;
    logic [31:0] sid;
    bit          chk;
    int          n_hdr;
    int          n_pay;
    int          exp_out;
    int          exp_pkt;
    int          exp_sid;
    int          exp_size;
    int          exp_seq;
    int          exp_ts;
  } vec_t;

  vec_t vecs[15];

  vita49_unpack dut (
    .AXIS_ACLK    (AXIS_ACLK),
    .AXIS_ARESETN (AXIS_ARESETN),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY),
    .enable       (enable),
    .sid_check    (sid_check),
    .streamID     (streamID),
    .ts_sec       (ts_sec),
    .ts_fsec      (ts_fsec),
    .ts_valid     (ts_valid),
    .pkt_cnt      (pkt_cnt),
    .sid_err      (sid_err),
    .size_err     (size_err),
    .seq_err      (seq_err)
  );

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  // Output-side ready: always, random, or never
  always @(posedge AXIS_ACLK) begin
    #1;
    case (ready_mode)
      0:       M_AXIS_TREADY = 1'b1;
      1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
      default: M_AXIS_TREADY = 1'b0;
    endcase
  end

  // Output monitor: collects accepted words, counts ts pulses, watches stall stability
  always @(negedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!M_AXIS_TVALID || M_AXIS_TDATA !== prev_data || M_AXIS_TLAST !== prev_last))
        stall_viol++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      if (ts_valid) ts_pulses++;
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
      prev_last  = M_AXIS_TLAST;
    end
  end

  function automatic vec_t mk(input logic [3:0] typ, input logic [3:0] seq, input logic [15:0] size,
                              input logic [31:0] sid, input bit chk, input int n_hdr, input int n_pay,
                              input int exp_out, input int p, input int si, input int sz, input int sq,
                              input int ts);
    vec_t v;
    v.typ = typ; v.seq = seq; v.size = size; v.sid = sid; v.chk = chk;
    v.n_hdr = n_hdr; v.n_pay = n_pay; v.exp_out = exp_out;
    v.exp_pkt = p; v.exp_sid = si; v.exp_size = sz; v.exp_seq = sq; v.exp_ts = ts;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one word and waits (bounded) for its handshake; call at posedge+1
  task automatic sendWord(input logic [31:0] d, input logic l, input bit gaps, output bit ok);
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      S_AXIS_TVALID = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge AXIS_ACLK);
      #1;
    end
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    ok = 0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge AXIS_ACLK);
      ok = S_AXIS_TREADY;
      @(posedge AXIS_ACLK);
      #1;
      n++;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL tready_timeout: got no handshake, expected one within 200 cycles");
    end
  endtask

  // Sends one packet built from a table record; sec word depends on idx
  task automatic applyStimulus(input vec_t v, input int idx, input bit gaps);
    logic [31:0] w[$];
    int n;
    bit ok;
    w.push_back({v.typ, 4'h0, 2'b01, 2'b10, v.seq, v.size});
    w.push_back(v.sid);
    w.push_back(32'h12345678 + 32'(idx));
    w.push_back(32'h00000001);
    w.push_back(32'h89ABCDEF);
    for (int k = 1; k <= v.n_pay; k++) w.push_back(32'(k));
    n = v.n_hdr + v.n_pay;
    sid_check = v.chk;
    for (int k = 0; k < n; k++) begin
      sendWord(w[k], k == n - 1, gaps, ok);
      if (!ok) return;
    end
  endtask

  // Compares collected output against repeated 1..per payload runs
  task automatic checkStream(input string tag, input int exp_n, input int per);
    checkOutput({tag, "_count"}, 64'(out_q.size()), 64'(exp_n));
    for (int j = 0; j < exp_n && j < out_q.size(); j++) begin
      logic [32:0] e;
      e[31:0] = 32'((j % per) + 1);
      e[32]   = ((j % per) == per - 1) || (j == exp_n - 1);
      checkOutput($sformatf("%s_word%0d", tag, j), 64'(out_q[j]), 64'(e));
    end
    out_q.delete();
  endtask

  task automatic checkCounters(input string tag, input int p, input int si, input int sz, input int sq);
    checkOutput({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(p));
    checkOutput({tag, "_sid_err"}, 64'(sid_err), 64'(si));
    checkOutput({tag, "_size_err"}, 64'(size_err), 64'(sz));
    checkOutput({tag, "_seq_err"}, 64'(seq_err), 64'(sq));
  endtask

  task automatic resetDut();
    AXIS_ARESETN = 1'b0;
    repeat (2) @(posedge AXIS_ACLK);
    #1;
    AXIS_ARESETN = 1'b1;
  endtask

  initial begin
    vec_t v;
    bit ok;
    int prev_ts;
    logic [31:0] exp_sec;
    logic [63:0] exp_fsec;

    //            typ   seq    size   sid           chk hdr pay out pkt sid size seq ts
    vecs[0]  = mk(4'h1, 4'd0,  16'd9, 32'hCAFE0001, 1,  5,  4,  4,  1,  0,  0,  0,  1);
    vecs[1]  = mk(4'h1, 4'd1,  16'd9, 32'hCAFE0001, 1,  5,  4,  4,  2,  0,  0,  0,  2);
    vecs[2]  = mk(4'h1, 4'd3,  16'd9, 32'hCAFE0001, 1,  5,  4,  4,  3,  0,  0,  1,  3);
    vecs[3]  = mk(4'h1, 4'd4,  16'd9, 32'hDEAD0000, 1,  5,  4,  0,  3,  1,  0,  1,  3);
    vecs[4]  = mk(4'h1, 4'd5,  16'd9, 32'hCAFE0001, 1,  5,  4,  4,  4,  1,  0,  1,  4);
    vecs[5]  = mk(4'h1, 4'd6,  16'd9, 32'hCAFE0001, 1,  5,  2,  2,  4,  1,  1,  1,  5);
    vecs[6]  = mk(4'h1, 4'd7,  16'd7, 32'hCAFE0001, 1,  5,  4,  2,  4,  1,  2,  1,  6);
    vecs[7]  = mk(4'h1, 4'd8,  16'd9, 32'hDEAD0000, 0,  5,  4,  4,  5,  1,  2,  1,  7);
    vecs[8]  = mk(4'h2, 4'd9,  16'd9, 32'hCAFE0001, 1,  5,  4,  0,  5,  1,  3,  1,  7);
    vecs[9]  = mk(4'h1, 4'd9,  16'd5, 32'hCAFE0001, 1,  5,  0,  0,  5,  1,  4,  1,  7);
    vecs[10] = mk(4'h1, 4'd9,  16'd6, 32'hCAFE0001, 1,  5,  1,  1,  6,  1,  4,  1,  8);
    vecs[11] = mk(4'h1, 4'd15, 16'd9, 32'hCAFE0001, 1,  5,  4,  4,  7,  1,  4,  2,  9);
    vecs[12] = mk(4'h1, 4'd0,  16'd9, 32'hCAFE0001, 1,  5,  4,  4,  8,  1,  4,  2,  10);
    vecs[13] = mk(4'h1, 4'd1,  16'd9, 32'hCAFE0001, 1,  3,  0,  0,  8,  1,  5,  2,  10);
    vecs[14] = mk(4'h1, 4'd2,  16'd9, 32'hCAFE0001, 1,  5,  4,  4,  9,  1,  5,  2,  11);

    AXIS_ARESETN  = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    enable        = 1'b1;
    sid_check     = 1'b1;
    streamID      = 32'hCAFE0001;
    resetDut();

    // Reset state
    @(negedge AXIS_ACLK);
    checkOutput("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("rst_m_tdata", 64'(M_AXIS_TDATA), 64'd0);
    checkOutput("rst_m_tlast", 64'(M_AXIS_TLAST), 64'd0);
    checkOutput("rst_ts_sec", 64'(ts_sec), 64'd0);
    checkOutput("rst_ts_fsec", ts_fsec, 64'd0);
    checkOutput("rst_ts_valid", 64'(ts_valid), 64'd0);
    checkOutput("rst_s_tready", 64'(S_AXIS_TREADY), 64'd1);
    checkCounters("rst", 0, 0, 0, 0);
    @(posedge AXIS_ACLK);
    #1;

    // Table-driven packets
    prev_ts  = 0;
    exp_sec  = '0;
    exp_fsec = '0;
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      applyStimulus(v, i, 1'b0);
      repeat (4) @(posedge AXIS_ACLK);
      @(negedge AXIS_ACLK);
      if (v.exp_ts != prev_ts) begin
        exp_sec  = 32'h12345678 + 32'(i);
        exp_fsec = 64'h00000001_89ABCDEF;
      end
      prev_ts = v.exp_ts;
      checkStream($sformatf("row%0d", i), v.exp_out, (v.exp_out > 0) ? v.exp_out : 1);
      checkCounters($sformatf("row%0d", i), v.exp_pkt, v.exp_sid, v.exp_size, v.exp_seq);
      checkOutput($sformatf("row%0d_ts_pulses", i), 64'(ts_pulses), 64'(v.exp_ts));
      checkOutput($sformatf("row%0d_ts_sec", i), 64'(ts_sec), 64'(exp_sec));
      checkOutput($sformatf("row%0d_ts_fsec", i), ts_fsec, exp_fsec);
      @(posedge AXIS_ACLK);
      #1;
    end

    // Three packets with random input gaps and output back-pressure
    resetDut();
    out_q.delete();
    stall_viol = 0;
    ready_mode = 1;
    for (int p = 0; p < 3; p++) begin
      v = vecs[0];
      v.seq = 4'(p);
      applyStimulus(v, 0, 1'b1);
    end
    for (int c = 0; c < 300 && out_q.size() < 12; c++) @(posedge AXIS_ACLK);
    ready_mode = 0;
    repeat (3) @(posedge AXIS_ACLK);
    @(negedge AXIS_ACLK);
    checkStream("stall", 12, 4);
    checkCounters("stall", 3, 0, 0, 0);
    checkOutput("stall_stability", 64'(stall_viol), 64'd0);
    @(posedge AXIS_ACLK);
    #1;

    // Reset while a payload word sits stalled in the output register
    ready_mode = 2;
    repeat (2) @(posedge AXIS_ACLK);
    #1;
    v = vecs[0];
    sendWord({4'h1, 4'h0, 2'b01, 2'b10, 4'd3, 16'd9}, 1'b0, 1'b0, ok);
    sendWord(32'hCAFE0001, 1'b0, 1'b0, ok);
    sendWord(32'h12345678, 1'b0, 1'b0, ok);
    sendWord(32'h00000001, 1'b0, 1'b0, ok);
    sendWord(32'h89ABCDEF, 1'b0, 1'b0, ok);
    sendWord(32'h00000001, 1'b0, 1'b0, ok);
    @(negedge AXIS_ACLK);
    checkOutput("midpay_held_valid", 64'(M_AXIS_TVALID), 64'd1);
    checkOutput("midpay_held_data", 64'(M_AXIS_TDATA), 64'd1);
    @(posedge AXIS_ACLK);
    #1;
    AXIS_ARESETN = 1'b0;
    @(posedge AXIS_ACLK);
    #1;
    AXIS_ARESETN = 1'b1;
    @(negedge AXIS_ACLK);
    checkOutput("midpay_rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    checkOutput("midpay_rst_ts_sec", 64'(ts_sec), 64'd0);
    checkCounters("midpay_rst", 0, 0, 0, 0);
    ready_mode = 0;
    repeat (2) @(posedge AXIS_ACLK);
    #1;
    out_q.delete();
    v.seq = 4'd7;
    applyStimulus(v, 0, 1'b0);
    repeat (4) @(posedge AXIS_ACLK);
    @(negedge AXIS_ACLK);
    checkStream("after_rst", 4, 4);
    checkCounters("after_rst", 1, 0, 0, 0);
    checkOutput("after_rst_ts_sec", 64'(ts_sec), 64'h12345678);
    @(posedge AXIS_ACLK);
    #1;

    // enable gates input ready while waiting for a header
    enable = 1'b0;
    @(negedge AXIS_ACLK);
    checkOutput("enable_low_tready", 64'(S_AXIS_TREADY), 64'd0);
    enable = 1'b1;
    @(negedge AXIS_ACLK);
    checkOutput("enable_high_tready", 64'(S_AXIS_TREADY), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
